// File: rtl/riskbes_pipe_pkg.sv
// Shared types and widths for the five-stage core's pipeline stage registers.
// The optional skid buffer is enabled by defining PIPE_STAGE_SKID_EN.
package riskbes_pipe_pkg;

  localparam int PIPE_OCC_W = 2;

  // Packed payload widths of the inter-stage registers
  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 150;
  localparam int EX_MEM_W = 106;
  localparam int MEM_WB_W = 71;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// Single payload slot with valid bit; used as the head slot and, with
// PIPE_STAGE_SKID_EN, as the skid slot of pipe_stage_reg.
module pipe_slot
  import riskbes_pipe_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] RESET_PAYLOAD = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  // Clear wins over load so a flush can never leave a stale entry behind
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      valid_q <= 1'b0;
      data_q  <= RESET_PAYLOAD;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush and hazard bubbles.
// Defining PIPE_STAGE_SKID_EN adds a second slot that cuts the ready path.
module pipe_stage_reg
  import riskbes_pipe_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] RESET_PAYLOAD = {WIDTH{1'b0}}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  hazard_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [PIPE_OCC_W-1:0] occupancy_o
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic             accept;
  logic             deq;
  logic             h_load;
  logic             h_clear;
  logic             h_valid;
  logic [WIDTH-1:0] h_d;
  logic [WIDTH-1:0] h_data;
`ifdef PIPE_STAGE_SKID_EN
  logic             s_load;
  logic             s_clear;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
`endif

  assign out_valid_o = h_valid & ~flush_i;
  assign out_data_o  = h_data;
  assign deq         = out_valid_o & out_ready_i;
  assign accept      = in_valid_i & in_ready_o;

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready_o  = (state_q != TWO) & ~rst_i & ~flush_i & ~hazard_i;
  assign occupancy_o = {1'b0, h_valid} + {1'b0, s_valid};
`else
  // Without the skid slot, a full head can only accept when it drains this cycle
  assign in_ready_o  = (~h_valid | out_ready_i) & ~rst_i & ~flush_i & ~hazard_i;
  assign occupancy_o = {1'b0, h_valid};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) state_d = ONE;
        end
        ONE: begin
          if (!accept && deq) state_d = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          if (accept && !deq) state_d = TWO;
`endif
        end
        TWO: begin
          if (deq) state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Slot controls; the skid slot refills the head when the head drains
  always_comb begin
    h_load  = 1'b0;
    h_clear = 1'b0;
    h_d     = in_data_i;
`ifdef PIPE_STAGE_SKID_EN
    s_load  = 1'b0;
    s_clear = 1'b0;
`endif
    if (flush_i) begin
      h_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      s_clear = 1'b1;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          h_load = accept;
        end
        ONE: begin
          if (accept && deq) h_load = 1'b1;
          if (!accept && deq) h_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          if (accept && !deq) s_load = 1'b1;
`endif
        end
        TWO: begin
`ifdef PIPE_STAGE_SKID_EN
          if (deq) begin
            h_load  = 1'b1;
            h_d     = s_data;
            s_clear = 1'b1;
          end
`endif
        end
        default: begin
          h_clear = 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(
    .WIDTH         (WIDTH),
    .RESET_PAYLOAD (RESET_PAYLOAD)
  ) u_head (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (h_load),
    .clear   (h_clear),
    .d       (h_d),
    .valid_q (h_valid),
    .data_q  (h_data)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_slot #(
    .WIDTH         (WIDTH),
    .RESET_PAYLOAD (RESET_PAYLOAD)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (s_load),
    .clear   (s_clear),
    .d       (in_data_i),
    .valid_q (s_valid),
    .data_q  (s_data)
  );
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the five-stage core. It is the common replacement for the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque packed payload with valid/ready flow control, supports flush and hazard-bubble insertion, and includes an optional two-entry skid buffer that breaks the ready path between stages. Decode and execute pack their control and data fields into `in_data_i`/`out_data_o`.

## Interface
Parameters:
- `WIDTH`, 32 — payload width in bits (≥1).
- `RESET_PAYLOAD`, `{WIDTH{1'b0}}` — payload value after reset, flush and bubble.

Ports:
- `clk_i`  in  1  — single clock; all state updates on its rising edge.
- `rst_i`  in  1  — reset, synchronous, active-high.
- `flush_i`  in  1  — kill all held entries at the next edge.
- `hazard_i`  in  1  — refuse upstream this cycle; downstream keeps draining.
- `in_valid_i`  in  1  — upstream entry valid.
- `in_ready_o`  out  1  — stage can accept.
- `in_data_i`  in  WIDTH  — upstream payload.
- `out_valid_o`  out  1  — head entry valid.
- `out_ready_i`  in  1  — downstream accepts.
- `out_data_o`  out  WIDTH  — head payload.
- `occupancy_o`  out  2  — held entries (0..2 with skid, 0..1 without).

## Operation
- accept = `in_valid_i & in_ready_o`; deq = `out_valid_o & out_ready_i`.
- `out_valid_o` = `head_valid_q & !flush_i`. Flushed entries are never consumed.
- Priority at each edge: `rst_i` > `flush_i` > normal update.
- On reset or flush, the next state is EMPTY, both slots load `RESET_PAYLOAD`, and no accept occurs.
- `in_ready_o` is forced to 0 while `rst_i`, `flush_i` or `hazard_i` is high.
- Skid-buffer states (head slot H, skid slot S):
  - EMPTY, on accept → ONE (H←in).
  - ONE:
    - accept & deq → ONE (H←in).
    - accept & !deq → TWO (S←in).
    - !accept & deq → EMPTY (H←`RESET_PAYLOAD`).
  - TWO:
    - deq → ONE (H←S, S←`RESET_PAYLOAD`).
    - Otherwise hold.
    - Accept is impossible in TWO.
- `in_ready_o` in skid mode = `(state != TWO) & !rst_i & !flush_i & !hazard_i`. There is no combinational path from `out_ready_i`.
- While `out_valid_o & !out_ready_i`, `out_data_o` is stable (absent flush and reset).
- Ordering is strictly FIFO. No entry is dropped or duplicated except by flush or reset.
- `occupancy_o`: EMPTY=0, ONE=1, TWO=2.

## Timing
- Reset values: `out_valid_o`=0, `out_data_o`=`RESET_PAYLOAD`, `occupancy_o`=0, `in_ready_o`=0 while `rst_i` is high and 1 in the first cycle after (unless hazard or flush is asserted).
- Latency: an entry accepted at edge N appears at `out_*` after edge N.
- Throughput: one entry per cycle sustained.
- Flush asserted in cycle N: `out_valid_o` drops in cycle N combinationally, and the stage is EMPTY after edge N.
- Reset asserted mid-stream with occupancy 2: the stage is EMPTY after that edge, and `flush_i` is ignored.
- `hazard_i` and `flush_i` asserted together: flush behaviour applies.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid buffer as above. `in_ready_o` is independent of `out_ready_i`. `occupancy_o` ranges 0..2.
- `PIPE_STAGE_SKID_EN` undefined: single slot H only. TWO is unreachable.
  - `in_ready_o` = `(!head_valid_q | out_ready_i) & !rst_i & !flush_i & !hazard_i`. This is a combinational path from `out_ready_i`.
  - accept & deq → H←in; deq only → EMPTY.
  - `occupancy_o[1]` is tied to 0.

## Structure
- Shared package `riskbes_pipe_pkg`:
  - State enum typedef `pipe_state_t` (EMPTY, ONE, TWO).
  - `PIPE_OCC_W`=2.
  - Per-stage payload width constants (`ID_EX_W`, `EX_MEM_W`, …).
- One sub-module, `pipe_slot`: a WIDTH-bit register with valid bit, `load`, `clear` (to `RESET_PAYLOAD`) and synchronous reset. It is instantiated as H, and as S under `PIPE_STAGE_SKID_EN`.
- The FSM and handshake logic live in the top module.

## Test plan
- Reset, then stream 0x1,0x2,0x3 with `out_ready_i`=1 → outputs 0x1,0x2,0x3 on consecutive cycles, one cycle after each accept; `occupancy_o`=1 throughout.
- Skid only: enqueue 0xA then 0xB with `out_ready_i`=0 → `occupancy_o`=2, `in_ready_o`=0, `out_data_o`=0xA stable. Raise `out_ready_i` → 0xA then 0xB.
- With occupancy 2, assert `flush_i` for one cycle → `out_valid_o`=0 that cycle; next cycle `occupancy_o`=0, `out_data_o`=`RESET_PAYLOAD`, `in_ready_o`=1.
- `hazard_i`=1 with `in_valid_i`=1, data 0x55, occupancy 1, `out_ready_i`=1 → `in_ready_o`=0, head drains, 0x55 not accepted. Drop hazard → 0x55 accepted next edge.
- Assert `rst_i` together with `flush_i` at occupancy 2 → all outputs at reset values next cycle, and no flush side effects.
- Random valid/ready (10k cycles) versus a scoreboard → FIFO order preserved, and no loss or duplication outside flush.
